// File: rtl/spi_master_ctrl.sv
// SPI mode-0, MSB-first master sequencer driving an external shift register.
// Generates SCK/CS_n plus the load and shift strobes; feeds sampled MISO back to the register LSB.
module spi_master_ctrl #(
    parameter int WIDTH   = 8,
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done,
    output logic sr_data_enable,
    output logic sr_shift_enable,
    output logic sr_shift_in,
    input  logic sr_shift_out,
    output logic spi_sck,
    output logic spi_cs_n,
    output logic spi_mosi,
    input  logic spi_miso
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [DIV_W-1:0]   div_cnt_r;
    logic [DIV_W-1:0]   div_cnt_nxt_s;
    logic [BIT_W-1:0]   bit_cnt_r;
    logic [BIT_W-1:0]   bit_cnt_nxt_s;
    logic               miso_q_r;
    logic               spi_sck_r;
    logic               spi_cs_n_r;
    logic               done_r;
    logic               data_en_s;
    logic               shift_en_s;
    logic               div_last_s;

    // Chip select is asserted for the whole bit window, from setup through the final low phase.
    function automatic logic cs_active(input state_t st);
        return (st == ST_SETUP) || (st == ST_HIGH) || (st == ST_LOW);
    endfunction

    assign div_last_s = (div_cnt_r == DIV_W'(CLK_DIV - 1));

    // Next-state, counter and strobe decode.
    always_comb begin
        state_nxt_s   = state_r;
        div_cnt_nxt_s = div_cnt_r;
        bit_cnt_nxt_s = bit_cnt_r;
        data_en_s     = 1'b0;
        shift_en_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                div_cnt_nxt_s = {DIV_W{1'b0}};
                bit_cnt_nxt_s = {BIT_W{1'b0}};
                if (start) begin
                    data_en_s   = 1'b1;
                    state_nxt_s = ST_SETUP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (div_last_s) begin
                    div_cnt_nxt_s = {DIV_W{1'b0}};
                    state_nxt_s   = ST_HIGH;
                end else begin
                    div_cnt_nxt_s = div_cnt_r + DIV_W'(1);
                end
            end
            ST_HIGH: begin
                // Shift on the same edge that drops SCK so MOSI moves after the falling edge.
                if (div_last_s) begin
                    shift_en_s    = 1'b1;
                    div_cnt_nxt_s = {DIV_W{1'b0}};
                    state_nxt_s   = ST_LOW;
                end else begin
                    div_cnt_nxt_s = div_cnt_r + DIV_W'(1);
                end
            end
            ST_LOW: begin
                if (div_last_s) begin
                    div_cnt_nxt_s = {DIV_W{1'b0}};
                    if (bit_cnt_r < BIT_W'(WIDTH - 1)) begin
                        bit_cnt_nxt_s = bit_cnt_r + BIT_W'(1);
                        state_nxt_s   = ST_HIGH;
                    end else begin
                        bit_cnt_nxt_s = {BIT_W{1'b0}};
                        state_nxt_s   = ST_DONE;
                    end
                end else begin
                    div_cnt_nxt_s = div_cnt_r + DIV_W'(1);
                end
            end
            ST_DONE: begin
                div_cnt_nxt_s = {DIV_W{1'b0}};
                bit_cnt_nxt_s = {BIT_W{1'b0}};
                state_nxt_s   = ST_IDLE;
            end
            default: begin
                div_cnt_nxt_s = {DIV_W{1'b0}};
                bit_cnt_nxt_s = {BIT_W{1'b0}};
                state_nxt_s   = ST_IDLE;
            end
        endcase
    end

    // State, counters, MISO sample and registered pin outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            div_cnt_r  <= {DIV_W{1'b0}};
            bit_cnt_r  <= {BIT_W{1'b0}};
            miso_q_r   <= 1'b0;
            spi_sck_r  <= 1'b0;
            spi_cs_n_r <= 1'b1;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            div_cnt_r  <= div_cnt_nxt_s;
            bit_cnt_r  <= bit_cnt_nxt_s;
            spi_sck_r  <= (state_nxt_s == ST_HIGH);
            spi_cs_n_r <= !cs_active(state_nxt_s);
            done_r     <= (state_nxt_s == ST_DONE);
            if ((state_r == ST_HIGH) && (div_cnt_r == {DIV_W{1'b0}})) begin
                miso_q_r <= spi_miso;
            end else begin
                miso_q_r <= miso_q_r;
            end
        end
    end

    assign busy            = (state_r != ST_IDLE);
    assign done            = done_r;
    assign sr_data_enable  = data_en_s;
    assign sr_shift_enable = shift_en_s;
    assign sr_shift_in     = miso_q_r;
    assign spi_sck         = spi_sck_r;
    assign spi_cs_n        = spi_cs_n_r;
    assign spi_mosi        = spi_cs_n_r ? 1'b0 : sr_shift_out;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl with a behavioural 8-bit shift register and SPI slave.
module tb_spi_master_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy;
    logic       done;
    logic       sr_data_enable;
    logic       sr_shift_enable;
    logic       sr_shift_in;
    logic       sr_shift_out;
    logic       spi_sck;
    logic       spi_cs_n;
    logic       spi_mosi;
    logic       spi_miso;

    logic [7:0] data_in;
    logic [7:0] sr_q = 8'h00;
    logic [1:0] mode;
    logic [7:0] slave_word;
    logic [7:0] slave_sh = 8'h00;

    typedef struct packed {
        logic [7:0]  tx;
        logic [7:0]  rx;
    } exp_t;

    typedef struct packed {
        logic [7:0]  rx;
        logic [7:0]  tx;
        logic [15:0] cycles;
        logic [7:0]  rises;
        logic [7:0]  falls;
        logic [7:0]  shifts;
        logic [7:0]  cslow;
        logic [7:0]  loads;
    } res_t;

    exp_t sb[$];
    res_t res[16];
    int   res_wr = 0;
    int   rd = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   cycle = 0;

    spi_master_ctrl #(.WIDTH(8), .CLK_DIV(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .busy            (busy),
        .done            (done),
        .sr_data_enable  (sr_data_enable),
        .sr_shift_enable (sr_shift_enable),
        .sr_shift_in     (sr_shift_in),
        .sr_shift_out    (sr_shift_out),
        .spi_sck         (spi_sck),
        .spi_cs_n        (spi_cs_n),
        .spi_mosi        (spi_mosi),
        .spi_miso        (spi_miso)
    );

    always #5 clk = ~clk;

    // Shift register the sequencer drives.
    always @(posedge clk) begin
        if (sr_data_enable) sr_q <= data_in;
        else if (sr_shift_enable) sr_q <= {sr_q[6:0], sr_shift_in};
    end
    assign sr_shift_out = sr_q[7];

    // MISO source: 0 loopback, 1 tied high, 2 slave model.
    assign spi_miso = (mode == 2'd0) ? spi_mosi : (mode == 2'd1) ? 1'b1 : slave_sh[7];

    always @(posedge clk) cycle <= cycle + 1;

    // Bus monitor: per-transaction counters and protocol violations.
    logic prev_sck = 1'b0, prev_csn = 1'b1, prev_shift = 1'b0, active = 1'b0;
    int   cyc = 0, rises = 0, falls = 0, shifts = 0, cslow = 0, loads = 0, viol = 0;
    logic [7:0] mosi_word = 8'h00;
    always @(negedge clk) begin
        prev_sck   <= spi_sck;
        prev_csn   <= spi_cs_n;
        prev_shift <= sr_shift_enable;
        if ((sr_data_enable && sr_shift_enable) || (spi_sck && spi_cs_n) ||
            (sr_shift_enable && !spi_sck) || (prev_shift && spi_sck))
            viol <= viol + 1;
        if (rst) begin
            active <= 1'b0;
        end else if (sr_data_enable && !active) begin
            active <= 1'b1; cyc <= 0; rises <= 0; falls <= 0; shifts <= 0;
            cslow <= 0; loads <= 1; mosi_word <= 8'h00;
        end else begin
            if (sr_data_enable) loads <= loads + 1;
            cyc <= cyc + 1;
            if (spi_sck && !prev_sck) begin
                rises <= rises + 1;
                mosi_word <= {mosi_word[6:0], spi_mosi};
            end
            if (!spi_sck && prev_sck) falls <= falls + 1;
            if (sr_shift_enable) shifts <= shifts + 1;
            if (!spi_cs_n) cslow <= cslow + 1;
            if (done) begin
                res[res_wr] <= '{sr_q, mosi_word, 16'(cyc + 1), 8'(rises), 8'(falls),
                                 8'(shifts), 8'(cslow), 8'(loads)};
                res_wr <= res_wr + 1;
                active <= 1'b0;
            end
        end
        if (prev_csn && !spi_cs_n) slave_sh <= slave_word;
        else if (!spi_sck && prev_sck) slave_sh <= {slave_sh[6:0], 1'b0};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output int stamp);
        logic seen;
        seen  = 1'b0;
        stamp = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen  = 1'b1;
                stamp = cycle;
            end
        end
        if (!seen) check("done_timeout", {31'd0, seen}, 32'd1);
    endtask

    task automatic compare_result(input string name);
        exp_t e;
        res_t r;
        #1;
        if (sb.size() > 0) e = sb.pop_front();
        else e = '{8'h00, 8'h00};
        r = res[rd];
        rd++;
        check({name, "_data_out"}, 32'(r.rx), 32'(e.rx));
        check({name, "_mosi"},     32'(r.tx), 32'(e.tx));
        check({name, "_cycles"},   32'(r.cycles), 32'd69);
        check({name, "_rises"},    32'(r.rises), 32'd8);
        check({name, "_falls"},    32'(r.falls), 32'd8);
        check({name, "_shifts"},   32'(r.shifts), 32'd8);
        check({name, "_cs_low"},   32'(r.cslow), 32'd68);
        check({name, "_loads"},    32'(r.loads), 32'd1);
        check({name, "_viol"},     32'(viol), 32'd0);
    endtask

    task automatic check_txn(input string name, output int stamp);
        wait_done(stamp);
        compare_result(name);
    endtask

    task automatic run_txn(input logic [7:0] tx, input logic [1:0] m,
                           input logic [7:0] sw, input logic [7:0] rx);
        @(posedge clk);
        #1;
        data_in    = tx;
        mode       = m;
        slave_word = sw;
        start      = 1'b1;
        sb.push_back('{tx, rx});
        @(negedge clk);
        check("load_strobe", {31'd0, sr_data_enable}, 32'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("busy_in_xfer", {31'd0, busy}, 32'd1);
    endtask

    initial begin
        int s0, s1, s2;
        rst = 1'b1; start = 1'b0; data_in = 8'h00; mode = 2'd0; slave_word = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cs_n", {31'd0, spi_cs_n}, 32'd1);
        check("rst_sck",  {31'd0, spi_sck},  32'd0);
        check("rst_busy", {31'd0, busy},     32'd0);
        check("rst_done", {31'd0, done},     32'd0);
        check("rst_mosi", {31'd0, spi_mosi}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        run_txn(8'hA5, 2'd0, 8'h00, 8'hA5);
        check_txn("loop_a5", s0);
        run_txn(8'h3C, 2'd1, 8'h00, 8'hFF);
        check_txn("miso1_3c", s0);
        run_txn(8'hC3, 2'd2, 8'h5A, 8'h5A);
        check_txn("slave_c3", s0);

        // start re-pulsed in cycles 10 and 69 must be ignored
        @(posedge clk);
        #1 data_in = 8'h69; mode = 2'd0; start = 1'b1;
        sb.push_back('{8'h69, 8'h69});
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1 start = 1'b1;
        @(negedge clk);
        check("repulse10_no_load", {31'd0, sr_data_enable}, 32'd0);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (58) @(posedge clk);
        #1 start = 1'b1;
        @(negedge clk);
        check("repulse69_done", {31'd0, done}, 32'd1);
        check("repulse69_no_load", {31'd0, sr_data_enable}, 32'd0);
        compare_result("repulse");
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        check("repulse_single_done", 32'(res_wr), 32'(rd));
        check("repulse_idle", {31'd0, busy}, 32'd0);

        // reset in cycle 30 aborts the transfer
        @(posedge clk);
        #1 data_in = 8'h5A; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (29) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_cs_n", {31'd0, spi_cs_n}, 32'd1);
        check("abort_sck",  {31'd0, spi_sck},  32'd0);
        check("abort_busy", {31'd0, busy},     32'd0);
        check("abort_done", {31'd0, done},     32'd0);
        repeat (100) @(negedge clk);
        check("abort_no_done", 32'(res_wr), 32'(rd));
        run_txn(8'h96, 2'd0, 8'h00, 8'h96);
        check_txn("after_rst", s0);

        // start held high: three back-to-back transactions
        @(posedge clk);
        #1 data_in = 8'h81; mode = 2'd0; start = 1'b1;
        for (int i = 0; i < 3; i++) sb.push_back('{8'h81, 8'h81});
        check_txn("b2b0", s0);
        check_txn("b2b1", s1);
        check("b2b_gap1", 32'(s1 - s0), 32'd70);
        check_txn("b2b2", s2);
        start = 1'b0;
        check("b2b_gap2", 32'(s2 - s1), 32'd70);

        repeat (10) @(negedge clk);
        check("done_count", 32'(res_wr), 32'(rd));
        check("final_viol", 32'(viol), 32'd0);
        check("final_idle", {31'd0, busy}, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
SPI mode-0 (CPOL=0, CPHA=0), MSB-first master sequencer that drives the team's shift_register block. It generates SCK and CS_n and the parallel-load and shift strobes for the shift register, and returns sampled MISO bits to it. TX data is loaded from the shift register's data_in. RX data is read from its data_out after done. The block sits between the host-side command logic and the external SPI pins.

Parameters:
WIDTH, 8, bits per transaction; must match the attached shift register width; >=1
CLK_DIV, 4, clk cycles per SCK half-period; must be >=2

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
start  input  1  request a transaction; accepted only in IDLE
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse at transaction end
sr_data_enable  output  1  parallel-load strobe to the shift register
sr_shift_enable  output  1  shift strobe to the shift register
sr_shift_in  output  1  MISO bit fed into the shift register LSB
sr_shift_out  input  1  shift register MSB; the current TX bit
spi_sck  output  1  SPI clock, idles low
spi_cs_n  output  1  chip select, active low
spi_mosi  output  1  master out
spi_miso  input  1  master in

Behaviour:
Reset and idle values:
- rst (any state, including mid-transfer): state=IDLE, spi_cs_n=1, spi_sck=0, done=0, busy=0, bit and divider counters=0, miso_q=0.
- rst overrides start in the same cycle.

Output timing:
- spi_sck, spi_cs_n and done are registered.
- busy, sr_data_enable and sr_shift_enable are decoded combinationally from state and counters.
- spi_mosi = spi_cs_n ? 0 : sr_shift_out (combinational).
- sr_shift_in = miso_q.

States: IDLE, SETUP, HIGH, LOW, DONE.
- IDLE: cs_n=1, sck=0.
  - If start=1, sr_data_enable=1 in that same cycle, so the shift register loads data_in at the next edge. Next state is SETUP.
  - When start=0, sr_data_enable=0.
- SETUP: cs_n=0, sck=0 for CLK_DIV cycles. Bit 0 (MSB) is presented on MOSI. Next state is HIGH.
- HIGH: sck=1 for CLK_DIV cycles.
  - miso_q <= spi_miso at the edge ending the first HIGH cycle.
  - sr_shift_enable=1 in the last HIGH cycle only. The shift register shifts in miso_q at the same edge where sck falls, so MOSI changes after the falling edge (mode 0).
  - Next state is LOW.
- LOW: sck=0 for CLK_DIV cycles. bit_cnt increments at LOW exit.
  - If bit_cnt < WIDTH-1, go to HIGH; otherwise go to DONE. The final LOW provides the CS hold time.
- DONE: cs_n=1, sck=0, done=1 for exactly one cycle. Next state is IDLE. The received word is now valid on the shift register data_out.

Latency:
- start seen in cycle 0.
- SETUP occupies cycles 1..CLK_DIV.
- Bits occupy 2*CLK_DIV*WIDTH cycles.
- done is high in cycle CLK_DIV*(2*WIDTH+1)+1.
- The earliest next start is accepted in the following cycle.
- Each transaction has exactly WIDTH rising and WIDTH falling SCK edges and WIDTH sr_shift_enable pulses.
- sr_data_enable and sr_shift_enable are never high in the same cycle.

Boundary conditions:
- start while busy (including DONE) is ignored: no load, no restart, no queueing.
- start held high continuously gives back-to-back transactions, separated by the single IDLE cycle.
- spi_miso is sampled only in HIGH; changes at other times have no effect.
- WIDTH=1: SETUP, HIGH, LOW, DONE.
- Counters must be sized for WIDTH and CLK_DIV. The divider wraps to 0 at every state change.

Test Plan:
Each bench instantiates shift_register(WIDTH=8) wired to the DUT; CLK_DIV=4.
- Loopback (miso=mosi), data_in=0xA5, start pulse -> MOSI at rising edges 1,0,1,0,0,1,0,1; data_out=0xA5 when done; done in cycle 69 after start.
- miso tied 1, data_in=0x3C -> MOSI bits 0,0,1,1,1,1,0,0; data_out=0xFF at done; exactly 8 sr_shift_enable pulses, each coincident with an sck 1->0 edge.
- External slave model returns 0x5A while master sends 0xC3 -> slave receives 0xC3, data_out=0x5A; cs_n low for exactly 68 cycles; sck low whenever cs_n=1.
- start re-pulsed in cycles 10 and 69 of a transfer -> ignored: no sr_data_enable, single done, timing unchanged.
- rst asserted in cycle 30 of a transfer -> next cycle cs_n=1, sck=0, busy=0, no done; a fresh start then completes normally with correct data.
- start held high for 3 transactions -> done pulses 70 cycles apart, each preceded by sr_data_enable in the IDLE cycle.
